// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for the DIP switches.
// Produces debounced levels with registered one-cycle rise/fall strobes.
module switch_debounce #(
    parameter int unsigned N         = 4,
    parameter int unsigned DB_CYCLES = 240000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_db,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_changed
);

    localparam int unsigned CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] cnt_next [N];
    logic [N-1:0]  db_next;
    logic [N-1:0]  rise_next;
    logic [N-1:0]  fall_next;

    // Per-bit STABLE/PENDING decision: a mismatch counts up, a match restarts.
    always_comb begin
        db_next   = sw_db;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_next[i] = '0;
            if (s2[i] != sw_db[i]) begin
                if (cnt[i] == TERM) begin
                    db_next[i]   = s2[i];
                    rise_next[i] = s2[i];
                    fall_next[i] = ~s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            sw_db      <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= sw_raw;
            s2         <= s1;
            sw_db      <= db_next;
            sw_rise    <= rise_next;
            sw_fall    <= fall_next;
            sw_changed <= |{rise_next, fall_next};
            for (int i = 0; i < int'(N); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with N=4, DB_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_switch_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] sw_db;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic       sw_changed;

    int checks;
    int failures;

    switch_debounce #(.N(4), .DB_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] db,
                           input logic [3:0] rise, input logic [3:0] fall);
        chk({tag, ".db"},   sw_db,   db);
        chk({tag, ".rise"}, sw_rise, rise);
        chk({tag, ".fall"}, sw_fall, fall);
        chk({tag, ".chg"},  {3'b000, sw_changed}, {3'b000, |{rise, fall}});
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Check n edges; the single expected event lands on edge ev (99 = none).
    task automatic watch(input string tag, input int n, input int ev,
                         input logic [3:0] db_before, input logic [3:0] db_after,
                         input logic [3:0] rise_ev, input logic [3:0] fall_ev);
        for (int k = 1; k <= n; k++) begin
            adv();
            @(negedge clk);
            chk_all($sformatf("%s@%0d", tag, k),
                    (k >= ev) ? db_after : db_before,
                    (k == ev) ? rise_ev : 4'b0000,
                    (k == ev) ? fall_ev : 4'b0000);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        sw_raw   = 4'b1111;

        // Reset with switches held high, then re-acceptance after release.
        watch("rst_hold", 3, 99, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        adv();
        reset = 1'b0;
        watch("rst_rel", 8, 6, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

        // Return to zero, then clean step to 0101.
        adv();
        sw_raw = 4'b0000;
        watch("to_zero", 8, 6, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        adv();
        sw_raw = 4'b0101;
        watch("step", 8, 6, 4'b0000, 4'b0101, 4'b0101, 4'b0000);
        adv();
        sw_raw = 4'b0000;
        watch("step_fall", 8, 6, 4'b0101, 4'b0000, 4'b0000, 4'b0101);

        // Bit 0 bounces 1,0,1,0 then settles high.
        adv(); sw_raw = 4'b0001; @(negedge clk); chk_all("bounce0", 4'b0000, 4'b0000, 4'b0000);
        adv(); sw_raw = 4'b0000; @(negedge clk); chk_all("bounce1", 4'b0000, 4'b0000, 4'b0000);
        adv(); sw_raw = 4'b0001; @(negedge clk); chk_all("bounce2", 4'b0000, 4'b0000, 4'b0000);
        adv(); sw_raw = 4'b0000; @(negedge clk); chk_all("bounce3", 4'b0000, 4'b0000, 4'b0000);
        adv(); sw_raw = 4'b0001;
        watch("settle", 8, 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        adv();
        sw_raw = 4'b0000;
        watch("settle_fall", 8, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        // Bit 2 high for only three cycles is rejected.
        adv();
        sw_raw = 4'b0100;
        watch("glitch_hi", 2, 99, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        adv();
        sw_raw = 4'b0000;
        watch("glitch_lo", 10, 99, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Bit 3 at cycle 0, bit 1 at cycle 2: independent strobes at edges 6 and 8.
        adv();
        sw_raw = 4'b1000;
        watch("indep", 1, 99, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        adv();
        sw_raw = 4'b1010;
        @(negedge clk);
        chk_all("indep@2", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 3; k <= 10; k++) begin
            logic [3:0] db_e;
            logic [3:0] rise_e;
            adv();
            @(negedge clk);
            db_e   = ((k >= 6) ? 4'b1000 : 4'b0000) | ((k >= 8) ? 4'b0010 : 4'b0000);
            rise_e = (k == 6) ? 4'b1000 : ((k == 8) ? 4'b0010 : 4'b0000);
            chk_all($sformatf("indep@%0d", k), db_e, rise_e, 4'b0000);
        end
        adv();
        sw_raw = 4'b0000;
        watch("indep_fall", 8, 6, 4'b1010, 4'b0000, 4'b0000, 4'b1010);

        // Reset pulsed at edge 4 of a pending bit-1 rise discards the count.
        adv();
        sw_raw = 4'b0010;
        watch("mid", 2, 99, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        adv();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        @(negedge clk);
        chk_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
        watch("mid_rel", 8, 6, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        adv();
        sw_raw = 4'b0000;
        watch("mid_fall", 8, 6, 4'b0010, 4'b0000, 4'b0000, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
